// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline stall/flush controller: mul/div FSM states,
// counter sizing and the stall-cause encoding used by the optional perf counters.
package pipeline_pkg;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 32;
    localparam int MD_CNT_W       = $clog2(DIV_CYCLES_DEF);

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_MEM,
        CAUSE_MD,
        CAUSE_HAZ
    } stall_cause_e;

    // One cause per cycle, memory wait dominating the others.
    function automatic stall_cause_e stall_cause(input logic mem_wait,
                                                 input logic md_stall,
                                                 input logic haz_stall);
        if (mem_wait)       return CAUSE_MEM;
        else if (md_stall)  return CAUSE_MD;
        else if (haz_stall) return CAUSE_HAZ;
        else                return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_muldiv_seq.sv
// Mul/div sequencer: IDLE -> BUSY (counts down) -> DONE (one-cycle pulse) -> IDLE.
// The done cycle lands exactly MUL_CYCLES/DIV_CYCLES cycles after the start cycle.
module muldiv_seq
    import pipeline_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic is_div_i,
    output logic idle_o,
    output logic busy_o,
    output logic done_o
);

    localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_e        r_state_reg;
    md_state_e        w_state_next;
    logic [CNT_W-1:0] r_cnt_reg;
    logic [CNT_W-1:0] w_cnt_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_reg <= MD_IDLE;
            r_cnt_reg   <= '0;
        end else begin
            r_state_reg <= w_state_next;
            r_cnt_reg   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state_reg;
        w_cnt_next   = r_cnt_reg;
        case (r_state_reg)
            MD_IDLE: begin
                if (start_i) begin
                    w_state_next = MD_BUSY;
                    w_cnt_next   = is_div_i ? DIV_LOAD : MUL_LOAD;
                end
            end
            MD_BUSY: begin
                // Leave BUSY in the cycle the counter reaches zero.
                w_cnt_next = r_cnt_reg - CNT_W'(1);
                if (r_cnt_reg <= CNT_W'(1)) begin
                    w_state_next = MD_DONE;
                end
            end
            MD_DONE: w_state_next = MD_IDLE;
            default: w_state_next = MD_IDLE;
        endcase
    end

    assign idle_o = (r_state_reg == MD_IDLE);
    assign busy_o = (r_state_reg == MD_BUSY) & ~rst_i;
    assign done_o = (r_state_reg == MD_DONE) & ~rst_i;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline. Define PIPELINE_PERF_EN to add
// 32-bit per-cause stall counters and a redirect counter.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        haz_stall_d_i,
    input  logic        haz_flush_d_i,
    input  logic        haz_flush_e_i,
    input  logic        imem_ready_i,
    input  logic        dmem_req_m_i,
    input  logic        dmem_ready_i,
    input  logic        md_start_e_i,
    input  logic        md_is_div_e_i,
    input  logic        md_use_d_i,
    output logic        stall_f_o,
    output logic        stall_d_o,
    output logic        stall_e_o,
    output logic        stall_m_o,
    output logic        flush_d_o,
    output logic        flush_e_o,
    output logic        flush_w_o,
    output logic        md_busy_o,
    output logic        md_done_o,
`ifdef PIPELINE_PERF_EN
    output logic [31:0] perf_mem_stall_o,
    output logic [31:0] perf_md_stall_o,
    output logic [31:0] perf_haz_stall_o,
    output logic [31:0] perf_redirect_o,
`endif
    output logic        redirect_pending_o
);

    logic w_mem_wait;
    logic w_md_idle;
    logic w_md_stall;
    logic w_d_stall;
    logic w_md_start;
    logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic w_flush_d, w_flush_e, w_flush_w;
    logic r_redirect_reg;
    logic w_redirect_next;

    assign w_mem_wait = dmem_req_m_i & ~dmem_ready_i;
    assign w_md_stall = md_use_d_i & ~w_md_idle;
    assign w_d_stall  = w_md_stall | haz_stall_d_i;
    assign w_md_start = md_start_e_i & ~w_stall_e;

    muldiv_seq #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_muldiv_seq (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (w_md_start),
        .is_div_i (md_is_div_e_i),
        .idle_o   (w_md_idle),
        .busy_o   (md_busy_o),
        .done_o   (md_done_o)
    );

    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_w = 1'b0;
        if (w_mem_wait) begin
            // Freeze F..M and drop every flush; the hazard unit re-raises them.
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_w = 1'b1;
        end else begin
            w_stall_f = w_d_stall | ~imem_ready_i;
            w_flush_d = haz_flush_d_i | r_redirect_reg | (~imem_ready_i & ~w_d_stall);
            w_stall_d = w_d_stall & ~w_flush_d;
            w_flush_e = w_d_stall | haz_flush_e_i;
        end
    end

    // Redirect waits for the wrong-path fetch to return; set beats clear, and
    // nothing moves while the memory stage holds the pipe.
    always_comb begin
        w_redirect_next = r_redirect_reg;
        if (!w_mem_wait) begin
            if (haz_flush_d_i && !imem_ready_i) begin
                w_redirect_next = 1'b1;
            end else if (imem_ready_i) begin
                w_redirect_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_redirect_reg <= 1'b0;
        end else begin
            r_redirect_reg <= w_redirect_next;
        end
    end

    assign stall_f_o          = w_stall_f & ~rst_i;
    assign stall_d_o          = w_stall_d & ~rst_i;
    assign stall_e_o          = w_stall_e & ~rst_i;
    assign stall_m_o          = w_stall_m & ~rst_i;
    assign flush_d_o          = w_flush_d & ~rst_i;
    assign flush_e_o          = w_flush_e & ~rst_i;
    assign flush_w_o          = w_flush_w & ~rst_i;
    assign redirect_pending_o = r_redirect_reg & ~rst_i;

`ifdef PIPELINE_PERF_EN
    stall_cause_e w_cause;
    logic [3:0]   w_perf_inc;
    logic [31:0]  r_perf_reg [4];

    assign w_cause    = stall_cause(w_mem_wait, w_md_stall, haz_stall_d_i);
    assign w_perf_inc = {haz_flush_d_i & ~w_mem_wait,
                         w_cause == CAUSE_HAZ,
                         w_cause == CAUSE_MD,
                         w_cause == CAUSE_MEM};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_perf
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_perf_reg[gi] <= '0;
                end else if (w_perf_inc[gi]) begin
                    r_perf_reg[gi] <= r_perf_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign perf_mem_stall_o = r_perf_reg[0];
    assign perf_md_stall_o  = r_perf_reg[1];
    assign perf_haz_stall_o = r_perf_reg[2];
    assign perf_redirect_o  = r_perf_reg[3];
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a table of single-cycle merge vectors plus
// hand-written sequences for mul/div timing, reset, memory wait and redirect.
module tb_pipeline_ctrl;

    logic clk_i = 1'b0;
    logic rst_i;
    logic haz_stall_d_i, haz_flush_d_i, haz_flush_e_i;
    logic imem_ready_i, dmem_req_m_i, dmem_ready_i;
    logic md_start_e_i, md_is_div_e_i, md_use_d_i;
    logic stall_f_o, stall_d_o, stall_e_o, stall_m_o;
    logic flush_d_o, flush_e_o, flush_w_o;
    logic md_busy_o, md_done_o, redirect_pending_o;
`ifdef PIPELINE_PERF_EN
    logic [31:0] perf_mem_stall_o, perf_md_stall_o, perf_haz_stall_o, perf_redirect_o;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    pipeline_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(32)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .haz_stall_d_i      (haz_stall_d_i),
        .haz_flush_d_i      (haz_flush_d_i),
        .haz_flush_e_i      (haz_flush_e_i),
        .imem_ready_i       (imem_ready_i),
        .dmem_req_m_i       (dmem_req_m_i),
        .dmem_ready_i       (dmem_ready_i),
        .md_start_e_i       (md_start_e_i),
        .md_is_div_e_i      (md_is_div_e_i),
        .md_use_d_i         (md_use_d_i),
        .stall_f_o          (stall_f_o),
        .stall_d_o          (stall_d_o),
        .stall_e_o          (stall_e_o),
        .stall_m_o          (stall_m_o),
        .flush_d_o          (flush_d_o),
        .flush_e_o          (flush_e_o),
        .flush_w_o          (flush_w_o),
        .md_busy_o          (md_busy_o),
        .md_done_o          (md_done_o),
`ifdef PIPELINE_PERF_EN
        .perf_mem_stall_o   (perf_mem_stall_o),
        .perf_md_stall_o    (perf_md_stall_o),
        .perf_haz_stall_o   (perf_haz_stall_o),
        .perf_redirect_o    (perf_redirect_o),
`endif
        .redirect_pending_o (redirect_pending_o)
    );

    // Inputs {haz_stall_d, haz_flush_d, haz_flush_e, imem_ready, dmem_req, dmem_ready, md_use_d}
    // Outputs {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
    typedef struct {
        string      name;
        logic [6:0] in;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [6:0] outs();
        return {stall_f_o, stall_d_o, stall_e_o, stall_m_o, flush_d_o, flush_e_o, flush_w_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_in();
        haz_stall_d_i = 1'b0;
        haz_flush_d_i = 1'b0;
        haz_flush_e_i = 1'b0;
        imem_ready_i  = 1'b1;
        dmem_req_m_i  = 1'b0;
        dmem_ready_i  = 1'b1;
        md_start_e_i  = 1'b0;
        md_is_div_e_i = 1'b0;
        md_use_d_i    = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clr_in();
        adv();
        rst_i = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"quiet",           7'b0001010, 7'b0000000};
        vecs[1]  = '{"haz_stall",       7'b1001010, 7'b1100010};
        vecs[2]  = '{"haz_flush_d",     7'b0101010, 7'b0000100};
        vecs[3]  = '{"haz_flush_e",     7'b0011010, 7'b0000010};
        vecs[4]  = '{"imem_wait",       7'b0000010, 7'b1000100};
        vecs[5]  = '{"stall_and_imem",  7'b1000010, 7'b1100010};
        vecs[6]  = '{"mem_wait_masks",  7'b1110100, 7'b1111001};
        vecs[7]  = '{"dmem_ready",      7'b0001110, 7'b0000000};
        vecs[8]  = '{"flush_over_stall",7'b1101010, 7'b1000110};
        vecs[9]  = '{"md_use_idle",     7'b0001011, 7'b0000000};
        vecs[10] = '{"dready_no_req",   7'b0001000, 7'b0000000};

        // Reset cycle: outputs forced low even with active requests.
        rst_i = 1'b1;
        clr_in();
        haz_stall_d_i = 1'b1;
        imem_ready_i  = 1'b0;
        @(negedge clk_i);
        chk("reset_outs", 32'(outs()), 32'h0);
        chk("reset_busy", 32'(md_busy_o), 32'h0);
        chk("reset_done", 32'(md_done_o), 32'h0);
        chk("reset_redir", 32'(redirect_pending_o), 32'h0);
        adv();
        do_reset();

        for (int i = 0; i < 11; i++) begin
            {haz_stall_d_i, haz_flush_d_i, haz_flush_e_i, imem_ready_i,
             dmem_req_m_i, dmem_ready_i, md_use_d_i} = vecs[i].in;
            @(negedge clk_i);
            chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
            $display("vec %0d %s in=%b outs=%b", i, vecs[i].name, vecs[i].in, outs());
            adv();
        end

        // Divide then dependent mfhi: stalled through BUSY and DONE.
        clr_in();
        md_start_e_i  = 1'b1;
        md_is_div_e_i = 1'b1;
        @(negedge clk_i);
        chk("div_start_busy", 32'(md_busy_o), 32'h0);
        adv();
        md_start_e_i = 1'b0;
        md_use_d_i   = 1'b1;
        for (int k = 1; k < 32; k++) begin
            @(negedge clk_i);
            chk("div_busy", 32'(md_busy_o), 32'h1);
            chk("div_no_done", 32'(md_done_o), 32'h0);
            chk("div_stall", 32'(outs()), 32'(7'b1100010));
            adv();
        end
        @(negedge clk_i);
        chk("div_done", 32'(md_done_o), 32'h1);
        chk("div_done_busy", 32'(md_busy_o), 32'h0);
        chk("div_done_stall", 32'(outs()), 32'(7'b1100010));
        $display("div: done pulse at cycle 32");
        adv();
        @(negedge clk_i);
        chk("div_after_done", 32'(md_done_o), 32'h0);
        chk("div_mfhi_go", 32'(outs()), 32'(7'b0000000));
        adv();

        // Reset while dividing with counter at 20.
        do_reset();
        md_start_e_i  = 1'b1;
        md_is_div_e_i = 1'b1;
        adv();
        md_start_e_i = 1'b0;
        for (int k = 1; k < 12; k++) adv();
        @(negedge clk_i);
        chk("mid_busy_pre", 32'(md_busy_o), 32'h1);
        adv();
        rst_i      = 1'b1;
        md_use_d_i = 1'b1;
        @(negedge clk_i);
        chk("mid_rst_busy", 32'(md_busy_o), 32'h0);
        chk("mid_rst_outs", 32'(outs()), 32'h0);
        adv();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_busy", 32'(md_busy_o), 32'h0);
        chk("post_rst_outs", 32'(outs()), 32'h0);
        $display("reset mid-busy: busy=%0b outs=%b", md_busy_o, outs());
        adv();

        // Data memory wait for 3 cycles with a pending D flush.
        clr_in();
        haz_flush_d_i = 1'b1;
        dmem_req_m_i  = 1'b1;
        dmem_ready_i  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("memwait_outs", 32'(outs()), 32'(7'b1111001));
            adv();
        end
        dmem_ready_i = 1'b1;
        @(negedge clk_i);
        chk("memwait_release", 32'(outs()), 32'(7'b0000100));
        $display("mem wait: release outs=%b", outs());
        adv();

        // Redirect while fetch is outstanding for two cycles.
        clr_in();
        haz_flush_d_i = 1'b1;
        imem_ready_i  = 1'b0;
        @(negedge clk_i);
        chk("redir_c0_outs", 32'(outs()), 32'(7'b1000100));
        chk("redir_c0_pend", 32'(redirect_pending_o), 32'h0);
        adv();
        haz_flush_d_i = 1'b0;
        @(negedge clk_i);
        chk("redir_c1_outs", 32'(outs()), 32'(7'b1000100));
        chk("redir_c1_pend", 32'(redirect_pending_o), 32'h1);
        adv();
        imem_ready_i = 1'b1;
        @(negedge clk_i);
        chk("redir_c2_outs", 32'(outs()), 32'(7'b0000100));
        chk("redir_c2_pend", 32'(redirect_pending_o), 32'h1);
        adv();
        @(negedge clk_i);
        chk("redir_c3_outs", 32'(outs()), 32'(7'b0000000));
        chk("redir_c3_pend", 32'(redirect_pending_o), 32'h0);
        $display("redirect: cleared after fetch return");
        adv();

        // Mult start held off by a memory wait, then a start seen in DONE.
        clr_in();
        md_start_e_i = 1'b1;
        dmem_req_m_i = 1'b1;
        dmem_ready_i = 1'b0;
        @(negedge clk_i);
        chk("mul_memwait_busy", 32'(md_busy_o), 32'h0);
        adv();
        dmem_ready_i = 1'b1;
        @(negedge clk_i);
        chk("mul_accept_busy", 32'(md_busy_o), 32'h0);
        chk("mul_accept_outs", 32'(outs()), 32'h0);
        adv();
        md_start_e_i = 1'b0;
        dmem_req_m_i = 1'b0;
        for (int k = 2; k < 6; k++) begin
            @(negedge clk_i);
            chk("mul_busy", 32'(md_busy_o), 32'h1);
            chk("mul_no_done", 32'(md_done_o), 32'h0);
            adv();
        end
        md_start_e_i = 1'b1;
        @(negedge clk_i);
        chk("mul_done", 32'(md_done_o), 32'h1);
        $display("mul: done pulse 5 cycles after acceptance");
        adv();
        @(negedge clk_i);
        chk("done_start_rejected", 32'(md_busy_o), 32'h0);
        chk("idle_no_done", 32'(md_done_o), 32'h0);
        adv();
        md_start_e_i = 1'b0;
        @(negedge clk_i);
        chk("idle_start_taken", 32'(md_busy_o), 32'h1);
        adv();

        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
